// File: rtl/uart_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_wb_pkg
// Brief    : Shared state encoding, protocol bytes and helpers for the
//            UART-to-Wishbone bridge master.
// Revision : 1.0 - initial release
// ============================================================================
package uart_wb_pkg;

  // Bridge controller states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } uwb_state_t;

  // Command bytes accepted from the host
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  // Response bytes returned to the host
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_TMO   = 8'h54;

  // Longest response: status byte plus 32-bit read data
  localparam int RESP_BYTES = 5;
  localparam int RESP_W     = RESP_BYTES * 8;

  // True for a byte that opens a valid frame
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage : uart_wb_pkg
`default_nettype wire

// File: rtl/uart_wb_resp_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_wb_resp_buf
// Brief    : Up-to-5-byte response buffer. A load captures the bytes
//            (first byte in the top bits) and a length; bytes then leave
//            one per tx_valid/tx_ready handshake. done flags the edge on
//            which the final byte is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module uart_wb_resp_buf
  import uart_wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [2:0]        len,
  input  logic [RESP_W-1:0] data,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              done
);

  logic [RESP_W-1:0] r_buf;
  logic [2:0]        r_left;
  logic              r_valid;
  logic              w_xfer;

  assign w_xfer   = r_valid && tx_ready;
  assign done     = w_xfer && (r_left == 3'd1);
  assign tx_valid = r_valid;
  assign tx_byte  = r_valid ? r_buf[RESP_W-1 -: 8] : 8'h00;

  // Load a new response, or shift out one byte per accepted handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_left  <= 3'd0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_buf   <= data;
      r_left  <= len;
      r_valid <= (len != 3'd0);
    end else if (w_xfer) begin
      r_buf   <= {r_buf[RESP_W-9:0], 8'h00};
      r_left  <= r_left - 3'd1;
      if (r_left == 3'd1) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule : uart_wb_resp_buf
`default_nettype wire

// File: rtl/uart_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_wb_master
// Brief    : Wishbone initiator driven by a UART byte stream. Host frames
//            'W' a3 a2 a1 a0 d3 d2 d1 d0 or 'R' a3 a2 a1 a0 (big-endian)
//            issue one single Wishbone cycle; the status / read data goes
//            back through the transmitter byte interface.
//            Optional build macro UWB_BYTE_GAP_EN: abort a partial frame
//            after BYTE_GAP_CYCLES idle cycles between its bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int BYTE_GAP_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        rx_overrun
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  uwb_state_t        r_state;
  uwb_state_t        w_next_state;
  logic              r_we;
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_adr;
  logic [31:0]       r_dat;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_rx_overrun;

  logic              w_in_bus;
  logic              w_timeout;
  logic              w_gap_abort;
  logic              w_resp_load;
  logic [2:0]        w_resp_len;
  logic [RESP_W-1:0] w_resp_data;
  logic              w_resp_done;

`ifdef UWB_BYTE_GAP_EN
  localparam int               GAP_W    = $clog2(BYTE_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_GAP_CYCLES - 1);

  logic [GAP_W-1:0] r_gap_cnt;

  // Count idle cycles inside a frame; any received byte restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
    end else if (((r_state == ST_ADDR) || (r_state == ST_DATA)) && !rx_valid) begin
      r_gap_cnt <= r_gap_cnt + GAP_W'(1);
    end else begin
      r_gap_cnt <= '0;
    end
  end

  // This idle cycle is the BYTE_GAP_CYCLES-th in a row: drop the frame
  assign w_gap_abort = ((r_state == ST_ADDR) || (r_state == ST_DATA)) &&
                       !rx_valid && (r_gap_cnt == GAP_LAST);
`else
  logic w_unused_gap;

  // Without the gap guard a partial frame simply waits for more bytes
  assign w_gap_abort  = 1'b0;
  assign w_unused_gap = ^BYTE_GAP_CYCLES;
`endif

  assign w_in_bus  = (r_state == ST_BUS);
  assign w_timeout = (r_wait_cnt == WAIT_LAST);

  // Bus outputs are decoded from the state register so an async reset
  // removes cyc/stb without waiting for a clock edge
  assign wbm_cyc_o  = w_in_bus;
  assign wbm_stb_o  = w_in_bus;
  assign wbm_we_o   = w_in_bus && r_we;
  assign wbm_sel_o  = w_in_bus ? 4'hF : 4'h0;
  assign wbm_adr_o  = w_in_bus ? r_adr : 32'h0;
  assign wbm_dat_o  = (w_in_bus && r_we) ? r_dat : 32'h0;
  assign busy       = (r_state != ST_IDLE);
  assign rx_overrun = r_rx_overrun;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and response buffer load requests
  always_comb begin
    w_next_state = r_state;
    w_resp_load  = 1'b0;
    w_resp_len   = 3'd0;
    w_resp_data  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (is_cmd(rx_byte)) begin
            w_next_state = ST_ADDR;
          end else begin
            w_next_state = ST_RESP;
            w_resp_load  = 1'b1;
            w_resp_len   = 3'd1;
            w_resp_data  = {RSP_ERR, 32'h0};
          end
        end
      end
      ST_ADDR: begin
        if (w_gap_abort) begin
          w_next_state = ST_IDLE;
        end else if (rx_valid && (r_byte_cnt == 2'd3)) begin
          w_next_state = r_we ? ST_DATA : ST_BUS;
        end
      end
      ST_DATA: begin
        if (w_gap_abort) begin
          w_next_state = ST_IDLE;
        end else if (rx_valid && (r_byte_cnt == 2'd3)) begin
          w_next_state = ST_BUS;
        end
      end
      ST_BUS: begin
        // An ack in the final wait cycle still completes the transfer
        if (wbm_ack_i) begin
          w_next_state = ST_RESP;
          w_resp_load  = 1'b1;
          if (r_we) begin
            w_resp_len  = 3'd1;
            w_resp_data = {RSP_OK, 32'h0};
          end else begin
            w_resp_len  = 3'd5;
            w_resp_data = {RSP_OK, wbm_dat_i};
          end
        end else if (w_timeout) begin
          w_next_state = ST_RESP;
          w_resp_load  = 1'b1;
          w_resp_len   = 3'd1;
          w_resp_data  = {RSP_TMO, 32'h0};
        end
      end
      ST_RESP: begin
        if (w_resp_done) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Frame assembly: command direction, byte counter and address/data shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_adr      <= 32'h0;
      r_dat      <= 32'h0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (rx_valid && is_cmd(rx_byte)) begin
            r_we       <= (rx_byte == CMD_WRITE);
            r_byte_cnt <= 2'd0;
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            r_adr      <= {r_adr[23:0], rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            r_dat      <= {r_dat[23:0], rx_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bus wait counter: zero outside BUS, so each transfer starts from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_in_bus) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Flag bytes that arrive while a transfer or response is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_overrun <= 1'b0;
    end else begin
      r_rx_overrun <= rx_valid && ((r_state == ST_BUS) || (r_state == ST_RESP));
    end
  end

  uart_wb_resp_buf u_resp_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_resp_load),
    .len      (w_resp_len),
    .data     (w_resp_data),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (w_resp_done)
  );

endmodule : uart_wb_master
`default_nettype wire

// File: tb/tb_uart_wb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_wb_master
// Brief    : Scoreboard bench for uart_wb_master. Stimulus pushes expected
//            bus cycles and response bytes; monitors pop and compare when
//            the DUT starts a bus cycle or hands over a tx byte.
//            Gap-abort scenario included when UWB_BYTE_GAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_wb_master;

  localparam int TMO = 16;
  localparam int GAP = 40;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } bus_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;
  logic        rx_overrun;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_tx[$];
  bus_t        exp_bus[$];

  int          ack_delay = 3;
  bit          ack_en    = 1'b1;
  logic [31:0] slv_rdata = 32'h0;
  int          slv_cnt   = 0;

  int          tx_seen   = 0;
  int          cyc_rises = 0;
  int          cyc_len   = 0;
  int          last_len  = 0;
  int          ovr_cnt   = 0;
  logic        prev_cyc  = 1'b0;

  uart_wb_master #(
    .TIMEOUT_CYCLES  (TMO),
    .BYTE_GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i),
    .busy       (busy),
    .rx_overrun (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: ack after ack_delay cycles of cyc/stb, returning slv_rdata
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (wbm_cyc_o && wbm_stb_o) begin
        slv_cnt   = slv_cnt + 1;
        wbm_ack_i = ack_en && (slv_cnt == ack_delay);
        wbm_dat_i = wbm_ack_i ? slv_rdata : 32'h0;
      end else begin
        slv_cnt   = 0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
      end
    end
  end

  // Response monitor: every accepted tx byte is checked against the queue
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      checks  = checks + 1;
      tx_seen = tx_seen + 1;
      if (exp_tx.size() == 0) begin
        errors = errors + 1;
        $display("FAIL tx_unexpected: got %02h, none expected", tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_tx.pop_front();
        if (tx_byte !== e) begin
          errors = errors + 1;
          $display("FAIL tx_byte: got %02h, expected %02h", tx_byte, e);
        end
      end
    end
  end

  // Bus monitor: the first cycle of each transfer is checked; cyc length tracked
  always @(negedge clk) begin
    if (wbm_cyc_o && !prev_cyc) begin
      cyc_rises = cyc_rises + 1;
      checks    = checks + 1;
      if (exp_bus.size() == 0) begin
        errors = errors + 1;
        $display("FAIL bus_unexpected: adr %08h, no cycle expected", wbm_adr_o);
      end else begin
        bus_t e;
        e = exp_bus.pop_front();
        if ({wbm_adr_o, wbm_dat_o, wbm_we_o} !== e || wbm_sel_o !== 4'hF || wbm_stb_o !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL bus_cycle: got adr %08h dat %08h we %0b sel %h stb %0b, expected adr %08h dat %08h we %0b sel f stb 1",
                   wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_stb_o, e.adr, e.dat, e.we);
        end
      end
    end
    if (wbm_cyc_o) begin
      cyc_len = cyc_len + 1;
    end else if (prev_cyc) begin
      last_len = cyc_len;
      cyc_len  = 0;
    end
    prev_cyc = wbm_cyc_o;
    if (rx_overrun) ovr_cnt = ovr_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic push_tx4(input logic [31:0] d);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
  endtask

  // Wait until the bridge is idle and every expected byte has been seen
  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks = checks + 1;
    if (busy || exp_tx.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_idle: busy %0b, %0d tx bytes outstanding after %0d cycles", name, busy, exp_tx.size(), budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   n;
    int   rises0;
    int   ovr0;
    logic [7:0] held;
    bit   stable;

    rst_n    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_tx", {tx_valid, tx_byte}, 9'h000);
    check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 7'h00);
    check("rst_adr_dat", {wbm_adr_o, wbm_dat_o}, 64'h0);
    check("rst_busy_ovr", {busy, rx_overrun}, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write 0xDEADBEEF to 0x30000004, ack after 3 cycles
    ack_delay = 3;
    exp_bus.push_back('{adr: 32'h3000_0004, dat: 32'hDEAD_BEEF, we: 1'b1});
    exp_tx.push_back(8'h4B);
    send_write(32'h3000_0004, 32'hDEAD_BEEF);
    check("write_cyc_latency", wbm_cyc_o, 1'b1);
    wait_done("write", 200);
    check("write_len", last_len, 3);

    // Read 0x30000008 -> 0x12345678, stall the transmitter mid-response
    slv_rdata = 32'h1234_5678;
    exp_bus.push_back('{adr: 32'h3000_0008, dat: 32'h0, we: 1'b0});
    exp_tx.push_back(8'h4B);
    push_tx4(32'h1234_5678);
    base = tx_seen;
    send_read(32'h3000_0008);
    n = 0;
    while (tx_seen < base + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("read_first_two", tx_seen - base, 2);
    tx_ready = 1'b0;
    @(negedge clk);
    held   = tx_byte;
    stable = tx_valid;
    repeat (10) begin
      @(negedge clk);
      if (!tx_valid || tx_byte !== held) stable = 1'b0;
    end
    check("stall_byte", held, 8'h34);
    check("stall_stable", stable, 1'b1);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_done("read", 200);
    check("read_count", tx_seen - base, 5);

    // Bad command
    rises0 = cyc_rises;
    exp_tx.push_back(8'h45);
    send_byte(8'h41);
    wait_done("badcmd", 50);
    check("badcmd_no_cyc", cyc_rises - rises0, 0);

    // Timeout: no ack, cyc must stay up exactly TMO cycles
    ack_en = 1'b0;
    exp_bus.push_back('{adr: 32'h3000_0010, dat: 32'h0, we: 1'b0});
    exp_tx.push_back(8'h54);
    send_read(32'h3000_0010);
    wait_done("timeout", TMO + 100);
    check("timeout_len", last_len, TMO);
    ack_en = 1'b1;

    // Overrun during BUS; result must be unaffected
    slv_rdata = 32'hCAFE_F00D;
    ack_delay = 6;
    ovr0 = ovr_cnt;
    exp_bus.push_back('{adr: 32'h3000_0020, dat: 32'h0, we: 1'b0});
    exp_tx.push_back(8'h4B);
    push_tx4(32'hCAFE_F00D);
    send_read(32'h3000_0020);
    send_byte(8'h99);
    wait_done("overrun", 200);
    check("overrun_pulses", ovr_cnt - ovr0, 1);

    // Reset during BUS drops cyc/stb immediately
    ack_en = 1'b0;
    exp_bus.push_back('{adr: 32'h3000_0040, dat: 32'h0, we: 1'b0});
    send_read(32'h3000_0040);
    @(posedge clk);
    #1;
    check("rstbus_cyc_before", wbm_cyc_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstbus_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 2'b00);
    check("rstbus_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    ack_en = 1'b1;
    ack_delay = 2;
    repeat (3) @(posedge clk);
    #1;
    check("rstbus_no_tx", tx_valid, 1'b0);

`ifdef UWB_BYTE_GAP_EN
    // Partial frame then silence: frame dropped, no response, no bus cycle
    rises0 = cyc_rises;
    base   = tx_seen;
    send_byte(8'h57);
    send_byte(8'h30);
    send_byte(8'h00);
    repeat (GAP + 5) @(posedge clk);
    #1;
    check("gap_idle", busy, 1'b0);
    check("gap_no_tx", tx_seen - base, 0);
    check("gap_no_cyc", cyc_rises - rises0, 0);
    slv_rdata = 32'hA5A5_0F0F;
    exp_bus.push_back('{adr: 32'h3000_000C, dat: 32'h0, we: 1'b0});
    exp_tx.push_back(8'h4B);
    push_tx4(32'hA5A5_0F0F);
    send_read(32'h3000_000C);
    wait_done("gap_read", 200);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("tx_queue_empty", exp_tx.size(), 0);
    check("bus_queue_empty", exp_bus.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_wb_master
`default_nettype wire

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Wishbone initiator driven by a byte stream from a UART receiver, with its response bytes returned to a UART transmitter.
- It is the bus-master counterpart of the UART/Wishbone slave peripherals.
- Lets a host PC read and write any 32-bit Wishbone address over the serial link (debug/bring-up bridge).
- Sits between uart_receive/uart_transmission byte interfaces and the user-area Wishbone bus.

Parameters:
- TIMEOUT_CYCLES, 1024: bus cycles to wait for wbm_ack_i before aborting a transaction.
- BYTE_GAP_CYCLES, 50000: max idle cycles between bytes of one frame; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rx_byte  in  8  received byte from the UART receiver
- rx_valid  in  1  one-cycle strobe, rx_byte valid; no backpressure
- tx_byte  out  8  response byte to the UART transmitter
- tx_valid  out  1  tx_byte valid; held until accepted
- tx_ready  in  1  transmitter accepts; transfer occurs when tx_valid && tx_ready
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  1 = write
- wbm_sel_o  out  4  byte selects, always 4'hF during a cycle
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge
- busy  out  1  high in any state other than IDLE
- rx_overrun  out  1  one-cycle pulse when an rx byte is dropped

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; registers cleared.
- Frame format, big-endian:
  - Write: cmd 0x57 ('W'), addr[31:24], addr[23:16], addr[15:8], addr[7:0], data[31:24] .. data[7:0].
  - Read: cmd 0x52 ('R'), then the 4 address bytes.
- Responses:
  - Write OK: 0x4B.
  - Read OK: 0x4B, then data[31:24] .. data[7:0].
  - Bad command: 0x45.
  - Bus timeout: 0x54.
- IDLE:
  - rx_valid with 0x57 or 0x52 -> ADDR; we_r set accordingly; byte counter = 0.
  - rx_valid with any other byte -> RESP with the single byte 0x45.
- ADDR: shift each byte into adr_r. On the 4th byte -> DATA if write, else BUS.
- DATA: shift 4 bytes into dat_r; 4th byte -> BUS.
- BUS:
  - Entered the cycle after the final frame byte. wbm_cyc_o = wbm_stb_o = 1, wbm_adr_o = adr_r, wbm_we_o = we_r, wbm_sel_o = 4'hF; wbm_dat_o = dat_r on writes, 0 on reads.
  - wait_cnt increments each BUS cycle.
  - wbm_ack_i = 1: wbm_dat_i captured that cycle; cyc/stb drop on the next edge; -> RESP with OK sequence.
  - wait_cnt reaching TIMEOUT_CYCLES-1 without ack: cyc/stb drop; -> RESP with 0x54.
  - Ack and timeout in the same cycle: ack wins.
  - Outside BUS, cyc/stb/we/sel/adr/dat outputs are 0.
- RESP:
  - tx_valid = 1 with the current byte, stable until tx_ready.
  - Each handshake advances the response index. After the last byte, tx_valid drops and state returns to IDLE in the same edge.
- rx_valid in BUS or RESP: byte discarded, rx_overrun pulses for 1 cycle.
- Latency: last frame byte -> cyc asserted, 1 cycle. Ack -> tx_valid, 1 cycle.
- Counters: byte counter 2 bits, wraps to 0 after the 4th byte. wait_cnt sized $clog2(TIMEOUT_CYCLES)+1 and cleared on entering BUS.
- Reset mid-transaction drops cyc/stb immediately (async).

Optional Feature:
- Macro: UWB_BYTE_GAP_EN.
- Defined:
  - In ADDR/DATA a gap counter counts cycles without rx_valid and is cleared by each rx_valid.
  - Reaching BYTE_GAP_CYCLES aborts the frame: -> IDLE, no response, no bus cycle.
- Undefined: no gap counter; a partial frame waits indefinitely; BYTE_GAP_CYCLES is unused.

Decomposition:
- Package uart_wb_pkg holds:
  - state encoding (IDLE, ADDR, DATA, BUS, RESP);
  - constants CMD_WRITE=8'h57, CMD_READ=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h45, RSP_TMO=8'h54.
- One sub-module is natural: uart_wb_resp_buf, a 5-byte response buffer and sequencer with load/length inputs and the tx valid/ready handshake.

Test Plan:
- Write: rx 57 30 00 00 04 DE AD BE EF -> one cycle with adr 0x30000004, dat 0xDEADBEEF, we=1, sel=F; slave acks after 3 cycles -> tx 4B.
- Read: rx 52 30 00 00 08; slave returns 0x12345678 with ack -> tx 4B 12 34 56 78 in order. Hold tx_ready low 10 cycles mid-sequence; bytes must stay stable and none lost.
- Bad command: rx 0x41 -> tx 45, busy returns to 0, no cyc asserted.
- Timeout: read with no ack -> cyc high exactly TIMEOUT_CYCLES cycles, then tx 54, then IDLE.
- Overrun: rx byte during BUS -> rx_overrun pulse, transaction result unchanged. Reset asserted during BUS -> cyc/stb 0 immediately, state IDLE.
- With UWB_BYTE_GAP_EN: rx 57 30 00, then silence for BYTE_GAP_CYCLES -> returns to IDLE, no tx; a following full read frame completes normally.
